yutorina_mem_stage: RTL and testbench

- MEM pipeline stage. Consumes the EX-stage pipeline register (ex_* signals) and performs word loads and stores over the shared bus with a request/grant/ready handshake.
- Raises busy to the pipeline controller for as long as an access is outstanding.
- Registers mem_* outputs for the WB stage: GPR write-back address, enable, data, exception code and control op.

---
 rtl/yutorina_mem_stage_pkg.sv | 64 ++++++
 rtl/yutorina_mem_stage_if.sv | 36 +++
 rtl/yutorina_bus_if.sv | 153 +++++++++++++++
 rtl/yutorina_mem_stage.sv | 147 ++++++++++++++
 tb/tb_yutorina_mem_stage.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/yutorina_mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// yutorina_mem_stage_pkg
// Shared definitions for the MEM pipeline stage: bus widths, active-low
// enable levels, memory/exception/control op encodings, bus direction and
// the MEM bus-access state encoding.
// ----------------------------------------------------------------------------
package yutorina_mem_stage_pkg;

   localparam int WORD_ADDR_W = 30;
   localparam int WORD_DATA_W = 32;
   localparam int GPR_ADDR_W  = 5;
   localparam int EXP_W       = 3;
   localparam int MEM_OP_W    = 2;
   localparam int CTRL_OP_W   = 2;

   typedef logic [WORD_ADDR_W-1:0] word_addr_t;
   typedef logic [WORD_DATA_W-1:0] word_data_t;
   typedef logic [GPR_ADDR_W-1:0]  gpr_addr_t;
   typedef logic [EXP_W-1:0]       exp_code_t;
   typedef logic [MEM_OP_W-1:0]    mem_op_t;
   typedef logic [CTRL_OP_W-1:0]   ctrl_op_t;

   // Active-low enable levels
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   // Bus direction
   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   // Memory operations
   localparam mem_op_t MEM_NONE = 2'd0;
   localparam mem_op_t MEM_LDW  = 2'd1;
   localparam mem_op_t MEM_STW  = 2'd2;

   // Exception codes
   localparam exp_code_t EXP_NONE       = 3'd0;
   localparam exp_code_t EXP_MISS_ALIGN = 3'd4;
   localparam exp_code_t EXP_BUS_ERR    = 3'd7;

   // Control ops and reset values
   localparam ctrl_op_t   CTRL_NONE = 2'd0;
   localparam gpr_addr_t  GPR_ZERO  = 5'd0;
   localparam word_addr_t ADDR_NULL = 30'd0;
   localparam word_data_t DATA_ZERO = 32'd0;

   // Bus access state
   typedef enum logic [1:0] {
      MEM_ST_IDLE   = 2'd0,
      MEM_ST_ACCESS = 2'd1,
      MEM_ST_HOLD   = 2'd2
   } mem_state_e;

   // True for the ops that need a bus cycle
   function automatic logic is_mem_op(input mem_op_t op);
      return (op == MEM_LDW) || (op == MEM_STW);
   endfunction

   // Word address of a byte address
   function automatic word_addr_t word_addr(input word_data_t byte_addr);
      return byte_addr[WORD_DATA_W-1:2];
   endfunction

endpackage

// File: rtl/yutorina_mem_stage_if.sv
// ----------------------------------------------------------------------------
// yutorina_mem_stage_if
// Shared-bus handshake bundle between the MEM stage (master) and the bus
// arbiter/slave side.
//   bus_req_    master -> slave  request, active-low
//   bus_grnt_   slave  -> master grant, active-low
//   bus_as_     master -> slave  address strobe, active-low
//   bus_rw      master -> slave  READ/WRITE
//   bus_addr    master -> slave  word address
//   bus_wr_data master -> slave  store data
//   bus_rd_data slave  -> master load data
//   bus_rdy_    slave  -> master ready, active-low
// ----------------------------------------------------------------------------
interface yutorina_mem_stage_if;
   import yutorina_mem_stage_pkg::*;

   logic       bus_req_;
   logic       bus_grnt_;
   logic       bus_as_;
   logic       bus_rw;
   word_addr_t bus_addr;
   word_data_t bus_wr_data;
   word_data_t bus_rd_data;
   logic       bus_rdy_;

   modport master (
      output bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
      input  bus_grnt_, bus_rd_data, bus_rdy_
   );

   modport slave (
      input  bus_req_, bus_as_, bus_rw, bus_addr, bus_wr_data,
      output bus_grnt_, bus_rd_data, bus_rdy_
   );

endinterface

// File: rtl/yutorina_bus_if.sv
// ----------------------------------------------------------------------------
// yutorina_bus_if
// Bus-access engine of the MEM stage: request/grant/ready FSM, load-data
// latch and ACCESS watchdog.
//   clk, rst     clock, asynchronous active-high reset
//   stall        pipeline stall (selects HOLD after completion)
//   access_req   aligned, exception-free load/store is waiting in EX
//   is_write     the pending access is a store
//   addr         word address, wr_data store data
//   bus          shared-bus master side
//   busy         access outstanding
//   complete     ready seen in ACCESS this cycle (load data on the bus)
//   bus_err      watchdog abort belongs to the instruction now in EX
//   rd_latch     last load data captured from the bus
// ----------------------------------------------------------------------------
module yutorina_bus_if
   import yutorina_mem_stage_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        stall,
   input  logic                        access_req,
   input  logic                        is_write,
   input  word_addr_t                  addr,
   input  word_data_t                  wr_data,
   yutorina_mem_stage_if.master        bus,
   output logic                        busy,
   output logic                        complete,
   output logic                        bus_err,
   output word_data_t                  rd_latch
);

   localparam int         CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);
   localparam bit         WD_EN  = (TIMEOUT != 0);

   mem_state_e       state_r;
   mem_state_e       state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic             timeout_s;
   logic             timeout_r;
   logic             enter_access_s;

   // Next-state and bus/handshake outputs from the current state
   always_comb begin
      state_nxt_s     = state_r;
      busy            = 1'b0;
      complete        = 1'b0;
      timeout_s       = 1'b0;
      bus.bus_req_    = DISABLE_;
      bus.bus_as_     = DISABLE_;
      bus.bus_rw      = READ;
      bus.bus_addr    = ADDR_NULL;
      bus.bus_wr_data = DATA_ZERO;
      if (rst) begin
         // Keep the bus released and busy low while reset is applied
         state_nxt_s = MEM_ST_IDLE;
      end else begin
         case (state_r)
            MEM_ST_IDLE: begin
               if (access_req) begin
                  bus.bus_req_ = ENABLE_;
                  busy         = 1'b1;
                  if (bus.bus_grnt_ == ENABLE_) begin
                     state_nxt_s = MEM_ST_ACCESS;
                  end else begin
                     state_nxt_s = MEM_ST_IDLE;
                  end
               end else begin
                  state_nxt_s = MEM_ST_IDLE;
               end
            end
            MEM_ST_ACCESS: begin
               bus.bus_req_    = ENABLE_;
               bus.bus_as_     = ENABLE_;
               bus.bus_rw      = is_write ? WRITE : READ;
               bus.bus_addr    = addr;
               bus.bus_wr_data = wr_data;
               if (bus.bus_rdy_ == ENABLE_) begin
                  complete    = 1'b1;
                  state_nxt_s = stall ? MEM_ST_HOLD : MEM_ST_IDLE;
               end else if (WD_EN && (cnt_r == TO_CNT)) begin
                  // Watchdog abort: release the pipeline as if the bus answered
                  timeout_s   = 1'b1;
                  state_nxt_s = stall ? MEM_ST_HOLD : MEM_ST_IDLE;
               end else begin
                  busy        = 1'b1;
                  state_nxt_s = MEM_ST_ACCESS;
               end
            end
            MEM_ST_HOLD: begin
               // Access already done; wait out the stall without re-issuing
               if (stall) begin
                  state_nxt_s = MEM_ST_HOLD;
               end else begin
                  state_nxt_s = MEM_ST_IDLE;
               end
            end
            default: begin
               state_nxt_s = MEM_ST_IDLE;
            end
         endcase
      end
   end

   assign enter_access_s = (state_r != MEM_ST_ACCESS) && (state_nxt_s == MEM_ST_ACCESS);

   // An abort in HOLD still belongs to the instruction waiting in EX
   assign bus_err = timeout_s || ((state_r == MEM_ST_HOLD) && timeout_r);

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= MEM_ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Watchdog counter: cleared on entry, counts cycles spent in ACCESS
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (enter_access_s) begin
         cnt_r <= '0;
      end else if (state_r == MEM_ST_ACCESS) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end
   end

   // Remember an abort so it survives a HOLD period
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timeout_r <= 1'b0;
      end else if (enter_access_s) begin
         timeout_r <= 1'b0;
      end else if (timeout_s) begin
         timeout_r <= 1'b1;
      end
   end

   // Capture read data on the ready cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_latch <= DATA_ZERO;
      end else if (complete) begin
         rd_latch <= bus.bus_rd_data;
      end
   end

endmodule

// File: rtl/yutorina_mem_stage.sv
// ----------------------------------------------------------------------------
// yutorina_mem_stage
// MEM pipeline stage: issues word loads/stores on the shared bus through
// yutorina_bus_if and registers the result for WB.
//   clk, rst        clock, asynchronous active-high reset
//   stall, flush    pipeline control from the controller
//   ex_*            EX-stage pipeline register (ex_out = byte address for
//                   memory ops, ALU result otherwise)
//   busy            access outstanding, controller must stall
//   bus             shared-bus master side
//   mem_*           registered outputs to WB; mem_out is write-back data
// ----------------------------------------------------------------------------
module yutorina_mem_stage
   import yutorina_mem_stage_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 ex_en_,
   input  word_addr_t           ex_pc,
   input  gpr_addr_t            ex_w_addr,
   input  word_data_t           ex_w_data,
   input  logic                 ex_gpr_we_,
   input  exp_code_t            ex_exp_code,
   input  mem_op_t              ex_mem_op,
   input  ctrl_op_t             ex_ctrl_op,
   input  word_data_t           ex_out,
   output logic                 busy,
   yutorina_mem_stage_if.master bus,
   output logic                 mem_en_,
   output word_addr_t           mem_pc,
   output gpr_addr_t            mem_w_addr,
   output logic                 mem_gpr_we_,
   output exp_code_t            mem_exp_code,
   output ctrl_op_t             mem_ctrl_op,
   output word_data_t           mem_out
);

   logic       mem_valid_s;
   logic       access_req_s;
   logic       misalign_s;
   logic       complete_s;
   logic       bus_err_s;
   word_data_t rd_latch_s;
   word_data_t out_nxt_s;
   logic       gpr_we_nxt_s;
   exp_code_t  exp_nxt_s;

   assign mem_valid_s  = (ex_en_ == ENABLE_) && is_mem_op(ex_mem_op);
   assign access_req_s = mem_valid_s && (ex_exp_code == EXP_NONE) && (ex_out[1:0] == 2'b00);
   assign misalign_s   = mem_valid_s && (ex_out[1:0] != 2'b00);

   yutorina_bus_if #(
      .TIMEOUT (TIMEOUT)
   ) u_bus_if (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .access_req (access_req_s),
      .is_write   (ex_mem_op == MEM_STW),
      .addr       (word_addr(ex_out)),
      .wr_data    (ex_w_data),
      .bus        (bus),
      .busy       (busy),
      .complete   (complete_s),
      .bus_err    (bus_err_s),
      .rd_latch   (rd_latch_s)
   );

   // Write-back data, GPR enable and exception for the instruction in EX
   always_comb begin
      out_nxt_s    = ex_out;
      gpr_we_nxt_s = ex_gpr_we_;
      exp_nxt_s    = ex_exp_code;
      case (ex_mem_op)
         MEM_LDW: begin
            // Bypass the latch on the ready cycle itself
            if (complete_s) begin
               out_nxt_s = bus.bus_rd_data;
            end else begin
               out_nxt_s = rd_latch_s;
            end
         end
         MEM_STW: begin
            out_nxt_s    = DATA_ZERO;
            gpr_we_nxt_s = DISABLE_;
         end
         default: begin
            out_nxt_s = ex_out;
         end
      endcase
      if (misalign_s) begin
         exp_nxt_s    = EXP_MISS_ALIGN;
         gpr_we_nxt_s = DISABLE_;
      end else if (bus_err_s) begin
         exp_nxt_s    = EXP_BUS_ERR;
         gpr_we_nxt_s = DISABLE_;
      end else begin
         exp_nxt_s    = ex_exp_code;
      end
   end

   // MEM/WB pipeline register; advances only when the pipeline is not stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_en_      <= DISABLE_;
         mem_pc       <= ADDR_NULL;
         mem_w_addr   <= GPR_ZERO;
         mem_gpr_we_  <= DISABLE_;
         mem_exp_code <= EXP_NONE;
         mem_ctrl_op  <= CTRL_NONE;
         mem_out      <= DATA_ZERO;
      end else if (!stall) begin
         if (flush) begin
            // Flushed slot keeps its valid/PC so the controller can trace it
            mem_en_      <= ex_en_;
            mem_pc       <= ex_pc;
            mem_w_addr   <= GPR_ZERO;
            mem_gpr_we_  <= DISABLE_;
            mem_exp_code <= EXP_NONE;
            mem_ctrl_op  <= CTRL_NONE;
            mem_out      <= DATA_ZERO;
         end else if (ex_en_ == ENABLE_) begin
            mem_en_      <= ex_en_;
            mem_pc       <= ex_pc;
            mem_w_addr   <= ex_w_addr;
            mem_gpr_we_  <= gpr_we_nxt_s;
            mem_exp_code <= exp_nxt_s;
            mem_ctrl_op  <= ex_ctrl_op;
            mem_out      <= out_nxt_s;
         end else begin
            // Bubble
            mem_en_      <= DISABLE_;
            mem_pc       <= ADDR_NULL;
            mem_w_addr   <= GPR_ZERO;
            mem_gpr_we_  <= DISABLE_;
            mem_exp_code <= EXP_NONE;
            mem_ctrl_op  <= CTRL_NONE;
            mem_out      <= DATA_ZERO;
         end
      end
   end

endmodule

// File: tb/tb_yutorina_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_yutorina_mem_stage
// Directed bench for the MEM stage. The controller stall is modelled as
// busy OR an extra stall request; grant/ready are driven cycle by cycle.
// ----------------------------------------------------------------------------
module tb_yutorina_mem_stage;
   import yutorina_mem_stage_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ext_stall = 1'b0;
   logic       stall;
   logic       flush = 1'b0;
   logic       ex_en_ = 1'b1;
   word_addr_t ex_pc = 30'd0;
   gpr_addr_t  ex_w_addr = 5'd0;
   word_data_t ex_w_data = 32'd0;
   logic       ex_gpr_we_ = 1'b1;
   exp_code_t  ex_exp_code = 3'd0;
   mem_op_t    ex_mem_op = 2'd0;
   ctrl_op_t   ex_ctrl_op = 2'd0;
   word_data_t ex_out = 32'd0;
   logic       busy;
   logic       mem_en_;
   word_addr_t mem_pc;
   gpr_addr_t  mem_w_addr;
   logic       mem_gpr_we_;
   exp_code_t  mem_exp_code;
   ctrl_op_t   mem_ctrl_op;
   word_data_t mem_out;

   int tests_run = 0;
   int tests_failed = 0;

   yutorina_mem_stage_if bus_i();

   assign stall = busy | ext_stall;

   yutorina_mem_stage #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .ex_en_(ex_en_), .ex_pc(ex_pc), .ex_w_addr(ex_w_addr), .ex_w_data(ex_w_data),
      .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code), .ex_mem_op(ex_mem_op),
      .ex_ctrl_op(ex_ctrl_op), .ex_out(ex_out), .busy(busy), .bus(bus_i),
      .mem_en_(mem_en_), .mem_pc(mem_pc), .mem_w_addr(mem_w_addr),
      .mem_gpr_we_(mem_gpr_we_), .mem_exp_code(mem_exp_code),
      .mem_ctrl_op(mem_ctrl_op), .mem_out(mem_out)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input mem_op_t op, input word_data_t out, input word_data_t wdata,
                          input gpr_addr_t waddr, input word_addr_t pc);
      ex_en_ = 1'b0; ex_mem_op = op; ex_out = out; ex_w_data = wdata;
      ex_w_addr = waddr; ex_pc = pc; ex_gpr_we_ = 1'b0; ex_exp_code = EXP_NONE; ex_ctrl_op = CTRL_NONE;
   endtask

   task automatic bubble();
      ex_en_ = 1'b1; ex_mem_op = MEM_NONE; ex_out = 32'd0; ex_gpr_we_ = 1'b1; ex_ctrl_op = CTRL_NONE;
   endtask

   task automatic test_reset();
      bus_i.bus_grnt_ = 1'b1; bus_i.bus_rdy_ = 1'b1; bus_i.bus_rd_data = 32'd0;
      rst = 1'b1;
      step();
      tests_run++; if (mem_en_ !== 1'b1) begin tests_failed++; $display("FAIL rst_mem_en: got %h want 1", mem_en_); end
      tests_run++; if (mem_out !== 32'd0 || mem_pc !== 30'd0 || mem_w_addr !== 5'd0) begin tests_failed++; $display("FAIL rst_mem_regs: got out=%h pc=%h wa=%h want 0", mem_out, mem_pc, mem_w_addr); end
      tests_run++; if (mem_gpr_we_ !== 1'b1 || mem_exp_code !== 3'd0 || mem_ctrl_op !== 2'd0) begin tests_failed++; $display("FAIL rst_mem_ctl: got we=%h exp=%h ctl=%h want 1/0/0", mem_gpr_we_, mem_exp_code, mem_ctrl_op); end
      tests_run++; if (busy !== 1'b0 || bus_i.bus_req_ !== 1'b1 || bus_i.bus_as_ !== 1'b1) begin tests_failed++; $display("FAIL rst_bus: got busy=%h req=%h as=%h want 0/1/1", busy, bus_i.bus_req_, bus_i.bus_as_); end
      tests_run++; if (bus_i.bus_rw !== 1'b1 || bus_i.bus_addr !== 30'd0 || bus_i.bus_wr_data !== 32'd0) begin tests_failed++; $display("FAIL rst_bus_data: got rw=%h a=%h d=%h want 1/0/0", bus_i.bus_rw, bus_i.bus_addr, bus_i.bus_wr_data); end
      rst = 1'b0;
   endtask

   task automatic test_nonmem();
      step();
      present(MEM_NONE, 32'h0000_1234, 32'd0, 5'd7, 30'h20);
      ex_ctrl_op = 2'd1;
      #1;
      tests_run++; if (busy !== 1'b0 || bus_i.bus_req_ !== 1'b1) begin tests_failed++; $display("FAIL nonmem_bus: got busy=%h req=%h want 0/1", busy, bus_i.bus_req_); end
      step();
      bubble();
      #1;
      tests_run++; if (mem_out !== 32'h0000_1234) begin tests_failed++; $display("FAIL nonmem_out: got %h want 00001234", mem_out); end
      tests_run++; if (mem_en_ !== 1'b0 || mem_pc !== 30'h20 || mem_w_addr !== 5'd7 || mem_gpr_we_ !== 1'b0 || mem_ctrl_op !== 2'd1) begin tests_failed++; $display("FAIL nonmem_pass: got en=%h pc=%h wa=%h we=%h ctl=%h want 0/20/7/0/1", mem_en_, mem_pc, mem_w_addr, mem_gpr_we_, mem_ctrl_op); end
      tests_run++; if (busy !== 1'b0 || bus_i.bus_req_ !== 1'b1) begin tests_failed++; $display("FAIL nonmem_bus2: got busy=%h req=%h want 0/1", busy, bus_i.bus_req_); end
   endtask

   task automatic test_ldw();
      int busy_cycles = 0;
      step();
      present(MEM_LDW, 32'h0000_0100, 32'd0, 5'd3, 30'h10);
      bus_i.bus_grnt_ = 1'b1; bus_i.bus_rdy_ = 1'b1; bus_i.bus_rd_data = 32'hDEAD_BEEF;
      #1;
      if (busy === 1'b1) busy_cycles++;
      tests_run++; if (bus_i.bus_req_ !== 1'b0) begin tests_failed++; $display("FAIL ldw_req: got %h want 0", bus_i.bus_req_); end
      step();
      bus_i.bus_grnt_ = 1'b0;
      #1;
      if (busy === 1'b1) busy_cycles++;
      step();
      bus_i.bus_grnt_ = 1'b1; bus_i.bus_rdy_ = 1'b0;
      #1;
      if (busy === 1'b1) busy_cycles++;
      tests_run++; if (bus_i.bus_as_ !== 1'b0 || bus_i.bus_addr !== 30'h40 || bus_i.bus_rw !== READ) begin tests_failed++; $display("FAIL ldw_access: got as=%h addr=%h rw=%h want 0/40/1", bus_i.bus_as_, bus_i.bus_addr, bus_i.bus_rw); end
      step();
      bubble(); bus_i.bus_rdy_ = 1'b1;
      #1;
      tests_run++; if (busy_cycles != 2) begin tests_failed++; $display("FAIL ldw_busy_cycles: got %0d want 2", busy_cycles); end
      tests_run++; if (mem_out !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL ldw_data: got %h want deadbeef", mem_out); end
      tests_run++; if (mem_gpr_we_ !== 1'b0 || mem_w_addr !== 5'd3 || mem_exp_code !== EXP_NONE) begin tests_failed++; $display("FAIL ldw_ctl: got we=%h wa=%h exp=%h want 0/3/0", mem_gpr_we_, mem_w_addr, mem_exp_code); end
      tests_run++; if (bus_i.bus_as_ !== 1'b1 || bus_i.bus_req_ !== 1'b1) begin tests_failed++; $display("FAIL ldw_release: got as=%h req=%h want 1/1", bus_i.bus_as_, bus_i.bus_req_); end
   endtask

   task automatic test_stw();
      step();
      present(MEM_STW, 32'h0000_0104, 32'hCAFE_F00D, 5'd5, 30'h11);
      bus_i.bus_grnt_ = 1'b1; bus_i.bus_rdy_ = 1'b1;
      #1;
      step();
      bus_i.bus_grnt_ = 1'b0;
      #1;
      step();
      bus_i.bus_grnt_ = 1'b1;
      #1;
      tests_run++; if (bus_i.bus_rw !== WRITE || bus_i.bus_wr_data !== 32'hCAFE_F00D || bus_i.bus_addr !== 30'h41) begin tests_failed++; $display("FAIL stw_bus: got rw=%h d=%h a=%h want 0/cafef00d/41", bus_i.bus_rw, bus_i.bus_wr_data, bus_i.bus_addr); end
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL stw_wait_busy: got %h want 1", busy); end
      step();
      step();
      step();
      bus_i.bus_rdy_ = 1'b0;
      #1;
      tests_run++; if (busy !== 1'b0 || bus_i.bus_as_ !== 1'b0) begin tests_failed++; $display("FAIL stw_rdy: got busy=%h as=%h want 0/0", busy, bus_i.bus_as_); end
      step();
      bubble(); bus_i.bus_rdy_ = 1'b1;
      #1;
      tests_run++; if (mem_out !== 32'd0 || mem_gpr_we_ !== 1'b1 || mem_exp_code !== EXP_NONE || mem_pc !== 30'h11) begin tests_failed++; $display("FAIL stw_wb: got out=%h we=%h exp=%h pc=%h want 0/1/0/11", mem_out, mem_gpr_we_, mem_exp_code, mem_pc); end
   endtask

   task automatic test_misalign();
      step();
      present(MEM_LDW, 32'h0000_0102, 32'd0, 5'd6, 30'h12);
      bus_i.bus_grnt_ = 1'b0;
      #1;
      tests_run++; if (bus_i.bus_req_ !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL mis_bus: got req=%h busy=%h want 1/0", bus_i.bus_req_, busy); end
      step();
      bubble(); bus_i.bus_grnt_ = 1'b1;
      #1;
      tests_run++; if (mem_exp_code !== EXP_MISS_ALIGN || mem_gpr_we_ !== 1'b1 || mem_en_ !== 1'b0) begin tests_failed++; $display("FAIL mis_wb: got exp=%h we=%h en=%h want 4/1/0", mem_exp_code, mem_gpr_we_, mem_en_); end
      tests_run++; if (bus_i.bus_as_ !== 1'b1) begin tests_failed++; $display("FAIL mis_no_access: got as=%h want 1", bus_i.bus_as_); end
   endtask

   task automatic test_stall_hold();
      int as_low = 0;
      step();
      present(MEM_LDW, 32'h0000_0200, 32'd0, 5'd4, 30'h13);
      bus_i.bus_grnt_ = 1'b1; bus_i.bus_rdy_ = 1'b1; bus_i.bus_rd_data = 32'h1122_3344;
      #1;
      step();
      bus_i.bus_grnt_ = 1'b0;
      #1;
      step();
      bus_i.bus_grnt_ = 1'b1; bus_i.bus_rdy_ = 1'b0; ext_stall = 1'b1;
      #1;
      if (bus_i.bus_as_ === 1'b0) as_low++;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL hold_rdy_busy: got %h want 0", busy); end
      step();
      bus_i.bus_rdy_ = 1'b1; bus_i.bus_rd_data = 32'hFFFF_FFFF;
      #1;
      if (bus_i.bus_as_ === 1'b0) as_low++;
      tests_run++; if (bus_i.bus_req_ !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL hold_idle_bus: got req=%h busy=%h want 1/0", bus_i.bus_req_, busy); end
      step();
      #1;
      if (bus_i.bus_as_ === 1'b0) as_low++;
      step();
      ext_stall = 1'b0;
      #1;
      if (bus_i.bus_as_ === 1'b0) as_low++;
      tests_run++; if (bus_i.bus_req_ !== 1'b1) begin tests_failed++; $display("FAIL hold_no_reissue: got req=%h want 1", bus_i.bus_req_); end
      step();
      bubble();
      #1;
      tests_run++; if (as_low != 1) begin tests_failed++; $display("FAIL hold_one_cycle: got %0d bus cycles want 1", as_low); end
      tests_run++; if (mem_out !== 32'h1122_3344 || mem_gpr_we_ !== 1'b0 || mem_w_addr !== 5'd4) begin tests_failed++; $display("FAIL hold_data: got out=%h we=%h wa=%h want 11223344/0/4", mem_out, mem_gpr_we_, mem_w_addr); end
   endtask

   task automatic test_flush();
      step();
      present(MEM_LDW, 32'h0000_0500, 32'd0, 5'd9, 30'h55);
      bus_i.bus_grnt_ = 1'b1; bus_i.bus_rdy_ = 1'b1; bus_i.bus_rd_data = 32'hA5A5_A5A5;
      #1;
      step();
      bus_i.bus_grnt_ = 1'b0;
      #1;
      step();
      bus_i.bus_grnt_ = 1'b1; flush = 1'b1;
      #1;
      tests_run++; if (busy !== 1'b1 || bus_i.bus_as_ !== 1'b0) begin tests_failed++; $display("FAIL flush_no_abort: got busy=%h as=%h want 1/0", busy, bus_i.bus_as_); end
      step();
      bus_i.bus_rdy_ = 1'b0;
      #1;
      step();
      bubble(); flush = 1'b0; bus_i.bus_rdy_ = 1'b1;
      #1;
      tests_run++; if (mem_en_ !== 1'b0 || mem_pc !== 30'h55) begin tests_failed++; $display("FAIL flush_pass: got en=%h pc=%h want 0/55", mem_en_, mem_pc); end
      tests_run++; if (mem_out !== 32'd0 || mem_gpr_we_ !== 1'b1 || mem_w_addr !== 5'd0) begin tests_failed++; $display("FAIL flush_clear: got out=%h we=%h wa=%h want 0/1/0", mem_out, mem_gpr_we_, mem_w_addr); end
   endtask

   task automatic test_timeout();
      int access_busy = 0;
      step();
      present(MEM_LDW, 32'h0000_0300, 32'd0, 5'd8, 30'h14);
      bus_i.bus_grnt_ = 1'b1; bus_i.bus_rdy_ = 1'b1;
      #1;
      step();
      bus_i.bus_grnt_ = 1'b0;
      #1;
      step();
      bus_i.bus_grnt_ = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (busy !== 1'b1) break;
         if (bus_i.bus_as_ === 1'b0) access_busy++;
         step();
      end
      tests_run++; if (access_busy != 4) begin tests_failed++; $display("FAIL to_cycles: got %0d busy ACCESS cycles want 4", access_busy); end
      tests_run++; if (busy !== 1'b0 || bus_i.bus_as_ !== 1'b0) begin tests_failed++; $display("FAIL to_abort: got busy=%h as=%h want 0/0", busy, bus_i.bus_as_); end
      step();
      bubble();
      #1;
      tests_run++; if (mem_exp_code !== EXP_BUS_ERR || mem_gpr_we_ !== 1'b1) begin tests_failed++; $display("FAIL to_exp: got exp=%h we=%h want 7/1", mem_exp_code, mem_gpr_we_); end
      tests_run++; if (bus_i.bus_as_ !== 1'b1) begin tests_failed++; $display("FAIL to_release: got as=%h want 1", bus_i.bus_as_); end
   endtask

   task automatic test_reset_mid();
      step();
      present(MEM_LDW, 32'h0000_0400, 32'd0, 5'd2, 30'h15);
      bus_i.bus_grnt_ = 1'b1; bus_i.bus_rdy_ = 1'b1;
      #1;
      step();
      bus_i.bus_grnt_ = 1'b0;
      #1;
      step();
      bus_i.bus_grnt_ = 1'b1;
      #1;
      tests_run++; if (bus_i.bus_as_ !== 1'b0) begin tests_failed++; $display("FAIL rmid_pre: got as=%h want 0", bus_i.bus_as_); end
      #1;
      rst = 1'b1;
      #1;
      tests_run++; if (bus_i.bus_as_ !== 1'b1 || bus_i.bus_req_ !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_bus: got as=%h req=%h busy=%h want 1/1/0", bus_i.bus_as_, bus_i.bus_req_, busy); end
      tests_run++; if (mem_en_ !== 1'b1 || mem_pc !== 30'd0 || mem_out !== 32'd0 || mem_exp_code !== 3'd0 || mem_gpr_we_ !== 1'b1) begin tests_failed++; $display("FAIL rmid_regs: got en=%h pc=%h out=%h exp=%h we=%h want reset", mem_en_, mem_pc, mem_out, mem_exp_code, mem_gpr_we_); end
      bubble();
      step();
      rst = 1'b0;
      step();
      #1;
      tests_run++; if (busy !== 1'b0 || bus_i.bus_as_ !== 1'b1) begin tests_failed++; $display("FAIL rmid_after: got busy=%h as=%h want 0/1", busy, bus_i.bus_as_); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "bench timeout");
   end

   initial begin
      test_reset();
      test_nonmem();
      test_ldw();
      test_stw();
      test_misalign();
      test_stall_hold();
      test_flush();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
